rr_mux_arbiter_4: RTL and testbench

Round-robin arbiter and registered output stage that generates the select index for a 4:1 data mux and consumes the selected word. Four requesters present W-bit words with valid/ready. The block grants one requester per cycle with rotating priority and latches the granted word into a single-entry output register. It drives `out_src`, the 2-bit select index, alongside the data so downstream logic knows the source.

---
 rtl/rr_mux_arbiter_4_pkg.sv | 21 ++
 rtl/rr_mux_arbiter_4_if.sv | 35 +++
 rtl/rr_mux_arbiter_4_pick.sv | 32 +++
 rtl/rr_mux_arbiter_4.sv | 104 ++++++++++
 tb/tb_rr_mux_arbiter_4.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_arbiter_4_pkg.sv
// rr_arb_pkg: shared types and helpers for the 4-way round-robin mux arbiter.
//   N_REQ     number of requesters (4)
//   req_idx_t 2-bit requester / select index
//   occ_t     output register occupancy (EMPTY/FULL)
//   next_idx  increment an index modulo 4
package rr_arb_pkg;

  localparam int unsigned N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } occ_t;

  function automatic req_idx_t next_idx(req_idx_t i);
    return req_idx_t'(i + 2'd1);
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_4_if.sv
// rr_mux_arbiter_4_if: bundle of requester-side and consumer-side handshake
// signals for rr_mux_arbiter_4.
//   in_valid[3:0], d0..d3   requester valids and words
//   in_ready[3:0]           per-requester accept (one-hot or zero)
//   out_valid/out_ready     output handshake
//   out_data, out_src       registered word and its source index
// Modports: slave = arbiter side, master = environment side.
interface rr_mux_arbiter_4_if
  import rr_arb_pkg::*;
#(
  parameter int unsigned W = 4
);

  logic [N_REQ-1:0] in_valid;
  logic [W-1:0]     d0;
  logic [W-1:0]     d1;
  logic [W-1:0]     d2;
  logic [W-1:0]     d3;
  logic [N_REQ-1:0] in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  req_idx_t         out_src;

  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, d0, d1, d2, d3, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_mux_arbiter_4_pick.sv
// rr_pick_4: combinational rotating-priority picker.
//   in_valid[3:0]  request vector
//   ptr            index with highest priority this cycle
//   grant_idx      first valid index scanning ptr, ptr+1, ... (mod 4)
//   any_valid      OR of in_valid
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] in_valid,
  input  req_idx_t         ptr,
  output req_idx_t         grant_idx,
  output logic             any_valid
);

  req_idx_t idx;
  logic     found;

  always_comb begin
    grant_idx = ptr;
    found     = 1'b0;
    idx       = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ptr + req_idx_t'(k);
      if (!found && in_valid[idx]) begin
        grant_idx = idx;
        found     = 1'b1;
      end
    end
    any_valid = |in_valid;
  end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: round-robin arbiter + single-entry registered 4:1 mux.
//   clk, rst   clock; asynchronous active-high reset
//   bus        rr_mux_arbiter_4_if.slave (requester and output handshakes)
//   xfer_cnt   count of output beats, present only with RR_MUX_ARB_CNT_EN
// Macro RR_MUX_ARB_CNT_EN enables the output beat counter.
module rr_mux_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
)(
  input  logic               clk,
  input  logic               rst,
  rr_mux_arbiter_4_if.slave  bus
`ifdef RR_MUX_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]   xfer_cnt
`endif
);

  if (W < 1 || CNT_W < 1) begin : g_bad_param
    $error("rr_mux_arbiter_4: W and CNT_W must be at least 1");
  end

  occ_t           state, state_next;
  logic [W-1:0]   data_q, data_next;
  req_idx_t       src_q, src_next;
  req_idx_t       ptr_q, ptr_next;
  req_idx_t       grant_idx;
  logic           any_valid;
  logic           load_en;
  logic [W-1:0]   sel_data;

  rr_pick_4 u_pick (
    .in_valid  (bus.in_valid),
    .ptr       (ptr_q),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    case (grant_idx)
      2'd0:    sel_data = bus.d0;
      2'd1:    sel_data = bus.d1;
      2'd2:    sel_data = bus.d2;
      default: sel_data = bus.d3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      src_q  <= '0;
      ptr_q  <= '0;
    end else begin
      state  <= state_next;
      data_q <= data_next;
      src_q  <= src_next;
      ptr_q  <= ptr_next;
    end
  end

  // Load is allowed when empty or when the held word drains this same edge.
  always_comb begin
    load_en    = (state == EMPTY) || bus.out_ready;
    state_next = state;
    data_next  = data_q;
    src_next   = src_q;
    ptr_next   = ptr_q;
    if (load_en) begin
      if (any_valid) begin
        state_next = FULL;
        data_next  = sel_data;
        src_next   = grant_idx;
        ptr_next   = next_idx(grant_idx);
      end else begin
        state_next = EMPTY;
      end
    end
  end

  // rst gates in_ready so no input handshake can complete during reset.
  always_comb begin
    bus.out_valid = (state == FULL);
    bus.out_data  = data_q;
    bus.out_src   = src_q;
    bus.in_ready  = '0;
    if (load_en && any_valid && !rst) begin
      bus.in_ready[grant_idx] = 1'b1;
    end
  end

`ifdef RR_MUX_ARB_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (state == FULL && bus.out_ready) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
module tb_rr_mux_arbiter_4;

  logic clk;
  logic rst;

  rr_mux_arbiter_4_if #(.W(4)) bus ();

`ifdef RR_MUX_ARB_CNT_EN
  logic [7:0] xfer_cnt;
`endif

  rr_mux_arbiter_4 #(.W(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef RR_MUX_ARB_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy, held word, held source, priority pointer, beat count.
  bit         m_valid;
  logic [3:0] m_data;
  int         m_src;
  int         m_ptr;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, "_out_data"},  32'(bus.out_data),  32'(m_data));
    chk({tag, "_out_src"},   32'(bus.out_src),   32'(m_src));
`ifdef RR_MUX_ARB_CNT_EN
    chk({tag, "_xfer_cnt"},  32'(xfer_cnt),      32'(m_cnt));
`endif
  endtask

  // One cycle: drive inputs, check combinational ready and held outputs,
  // clock the edge and advance the model. Entered and left at posedge+1.
  task automatic step(input logic [3:0] v, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] e, input logic ordy);
    int         g;
    logic [3:0] exp_rdy;
    logic [3:0] words [4];
    bus.in_valid  = v;
    bus.d0        = a;
    bus.d1        = b;
    bus.d2        = c;
    bus.d3        = e;
    bus.out_ready = ordy;
    words[0] = a; words[1] = b; words[2] = c; words[3] = e;
    #1;
    g = pick(v, m_ptr);
    exp_rdy = '0;
    if ((!m_valid || ordy) && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check_outs("pre");
    @(posedge clk);
    if (m_valid && ordy) m_cnt = (m_cnt + 1) % 256;
    if (!m_valid || ordy) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = words[g];
        m_src   = g;
        m_ptr   = (g + 1) % 4;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  // Asynchronous reset asserted between edges, released after one edge.
  task automatic mid_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_in_ready", 32'(bus.in_ready), 32'd0);
    check_outs("async_rst");
    @(posedge clk);
    #1;
    chk("rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.d0        = 4'd5;
    bus.d1        = 4'd6;
    bus.d2        = 4'd7;
    bus.d3        = 4'd8;
    bus.out_ready = 1'b1;
    model_reset();

    // Reset held over two edges with requests pending: nothing accepted.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check_outs("reset");
    rst = 1'b0;

    // Idle.
    repeat (3) step(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

    // Fairness: all requesting, full throughput.
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
      chk("fair_src",  32'(bus.out_src),  32'(i % 4));
      chk("fair_data", 32'(bus.out_data), 32'(i % 4 + 1));
    end

    // Backpressure: load requester 2, stall 3 cycles, release.
    step(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    chk("bp_src", 32'(bus.out_src), 32'd2);
    repeat (3) step(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    chk("bp_hold_data", 32'(bus.out_data), 32'd3);
    step(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    chk("bp_release_src", 32'(bus.out_src), 32'd3);

    // Skip and wrap: pointer lands on 3, only 2 requests, then only 3.
    step(4'b0100, 4'd0, 4'd0, 4'd9, 4'd0, 1'b1);
    step(4'b0100, 4'd0, 4'd0, 4'd9, 4'd0, 1'b1);
    chk("skip_data", 32'(bus.out_data), 32'd9);
    step(4'b1000, 4'd0, 4'd0, 4'd9, 4'd11, 1'b1);
    chk("wrap_src", 32'(bus.out_src), 32'd3);
    step(4'b1111, 4'd12, 4'd13, 4'd14, 4'd15, 1'b1);
    chk("wrap_next_src", 32'(bus.out_src), 32'd0);

    // Drain: no requests, held word leaves, data holds.
    step(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("drain_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_data",  32'(bus.out_data),  32'd12);

    // Mid-stream reset after a fresh 5-beat stream.
    mid_reset();
    repeat (5) step(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    check_outs("stream5");
    mid_reset();
    step(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    chk("post_rst_src", 32'(bus.out_src), 32'd0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 50) mid_reset();
      step(4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end
    check_outs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
